fog_param_uart_regs: RTL and testbench
======================================

# fog_param_uart_regs

UART command receiver and parameter register bank on the CPU clock domain, feeding the `var_*` parameter inputs of the FOG core (`HINS_fog_v1`). It replaces the hard-wired constants at top level. It deserialises `FPGA_RX`, parses fixed 9-byte command frames, and updates one 32-bit parameter per valid frame. Every output holds its power-on default until a valid write arrives.

## Interface
- CLK_HZ, 100000000, CPU clock frequency in Hz
- BAUD, 115200, UART bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division)
- TIMEOUT_CLKS, 1000000, inter-byte idle limit before the parser aborts a partial frame
- pll_clk_cpu_int  in  1  clock; all logic is on this clock
- RST_EXT_N  in  1  asynchronous, active-low reset
- i_rx  in  1  UART RX line (FPGA_RX), asynchronous to the clock, idle high
- var_freq_cnt, var_amp_H, var_amp_L, var_wait_cnt, var_err_offset, var_avg_sel, var_gainSel_step, var_gainSel_ramp, var_fb_ON, var_const_step  out  32 each  parameter registers
- var_polarity  out  1  polarity register
- o_param_update  out  1  one-cycle pulse when a parameter is written
- o_param_addr  out  8  address of the last write; held between writes
- o_frame_err  out  1  one-cycle pulse on a UART framing error or a bad frame

## Operation
- Frame layout, 9 bytes: 0xAB, 0xBA, ADDR, D3, D2, D1, D0 (big-endian), 0x55, 0x56.
- Address map:
  - 0x01 freq_cnt, 0x02 amp_H, 0x03 amp_L, 0x04 polarity (D0 bit0 only)
  - 0x05 wait_cnt, 0x06 err_offset, 0x07 avg_sel, 0x08 gainSel_step
  - 0x09 gainSel_ramp, 0x0A fb_ON, 0x0B const_step
- Reset values:
  - freq_cnt 1000, amp_H 5000, amp_L 5000, polarity 0, wait_cnt 50, err_offset 0
  - avg_sel 10, gainSel_step 5, gainSel_ramp 10, fb_ON 1, const_step 100
  - o_param_update 0, o_param_addr 0x00, o_frame_err 0
- UART receiver:
  - i_rx passes through a 2-FF synchroniser.
  - A start bit is a falling edge seen in the idle state. The line is re-sampled at CLKS_PER_BIT/2; if it is high, treat it as a glitch and return to idle.
  - Each of 8 data bits (LSB first) is sampled at mid-bit. The stop bit is sampled the same way.
  - Stop bit = 1: issue a 1-cycle byte_valid with the byte.
  - Stop bit = 0: no byte_valid; pulse o_frame_err and reset the parser to IDLE.
- Parser FSM states: IDLE, HDR2, ADDR, DATA (2-bit index, 4 bytes), TRL1, TRL2.
  - IDLE: 0xAB → HDR2; any other byte is ignored.
  - HDR2: 0xBA → ADDR; 0xAB → stay in HDR2; any other byte → IDLE.
  - ADDR: latch the byte → DATA.
  - DATA: shift each byte into a 32-bit buffer; after the 4th byte → TRL1.
  - TRL1: 0x55 → TRL2; otherwise o_frame_err and → IDLE.
  - TRL2: 0x56 with ADDR in 0x01..0x0B → write. 0x56 with any other ADDR, or any byte other than 0x56 → o_frame_err, no write. Both cases → IDLE.
- Timeout: the idle counter is cleared on every byte_valid and counts only while the FSM is not in IDLE. At TIMEOUT_CLKS it forces IDLE silently (no error pulse).
- Writes for bits outside var_polarity's width are discarded. Writing the current value still pulses o_param_update.

## Timing
- On a valid write, the register, o_param_addr and o_param_update all change on the clock edge after the byte_valid of the final 0x56 byte. o_param_update is high for exactly one cycle.
- All outputs are registered; there is no combinational path from i_rx.
- byte_valid occurs about CLKS_PER_BIT/2 + 2 cycles after the nominal start of the stop bit (mid-bit sample plus synchroniser delay).
- Back-to-back frames with no idle gap must all be accepted.
- Reset mid-frame: all state and outputs return to reset values immediately. A partial frame is never applied.
- Outputs change only on a write, so a downstream consumer on CLOCK_ADC handles the crossing. o_param_update is the qualifier for that crossing.

## Structure
- Package fog_param_pkg holds:
  - address localparams or an enum (ADDR_FREQ_CNT … ADDR_CONST_STEP)
  - HDR0/HDR1/TRL0/TRL1 byte constants
  - all reset-default constants
  - the parser state enum
- Sub-module uart_rx_byte: synchroniser, bit counter, mid-bit sampling. Outputs are byte_valid, byte_data and stop_err.
- The top level of this block contains the parser FSM, data buffer, timeout counter and register bank.

## Test plan
Run with CLK_HZ=1000000, BAUD=100000 (10 clocks/bit) and TIMEOUT_CLKS=500.
- Release reset with no traffic → all outputs equal the reset defaults; o_param_update and o_frame_err stay 0.
- Frame AB BA 01 00 00 07 D0 55 56 → var_freq_cnt=2000, o_param_addr=0x01, one update pulse; all other registers unchanged.
- Frame AB BA 04 00 00 00 03 55 56 → var_polarity=1; then AB AB BA 0B FF FF FF 9C 55 56 → var_const_step=0xFFFFFF9C (-100).
- Frame with trailer 55 57, addr 0x0C, or data stop bit forced low → exactly one o_frame_err pulse, no register change, next valid frame is accepted.
- Send AB BA 02 00 00, idle 600 clocks, then a full valid frame for addr 0x02 → only the second frame is applied; no error pulse.
- Assert RST_EXT_N low after the 5th byte of a frame → outputs return to defaults immediately; the remaining bytes after release produce no write.

Source files
------------

// File: rtl/fog_param_pkg.sv
// Shared constants for the FOG parameter UART: frame bytes, register addresses,
// power-on defaults and the command parser state encoding.
package fog_param_pkg;

    localparam logic [7:0] HDR0 = 8'hAB;
    localparam logic [7:0] HDR1 = 8'hBA;
    localparam logic [7:0] TRL0 = 8'h55;
    localparam logic [7:0] TRL1 = 8'h56;

    localparam logic [7:0] ADDR_FREQ_CNT     = 8'h01;
    localparam logic [7:0] ADDR_AMP_H        = 8'h02;
    localparam logic [7:0] ADDR_AMP_L        = 8'h03;
    localparam logic [7:0] ADDR_POLARITY     = 8'h04;
    localparam logic [7:0] ADDR_WAIT_CNT     = 8'h05;
    localparam logic [7:0] ADDR_ERR_OFFSET   = 8'h06;
    localparam logic [7:0] ADDR_AVG_SEL      = 8'h07;
    localparam logic [7:0] ADDR_GAINSEL_STEP = 8'h08;
    localparam logic [7:0] ADDR_GAINSEL_RAMP = 8'h09;
    localparam logic [7:0] ADDR_FB_ON        = 8'h0A;
    localparam logic [7:0] ADDR_CONST_STEP   = 8'h0B;

    localparam logic [31:0] RST_FREQ_CNT     = 32'd1000;
    localparam logic [31:0] RST_AMP_H        = 32'd5000;
    localparam logic [31:0] RST_AMP_L        = 32'd5000;
    localparam logic        RST_POLARITY     = 1'b0;
    localparam logic [31:0] RST_WAIT_CNT     = 32'd50;
    localparam logic [31:0] RST_ERR_OFFSET   = 32'd0;
    localparam logic [31:0] RST_AVG_SEL      = 32'd10;
    localparam logic [31:0] RST_GAINSEL_STEP = 32'd5;
    localparam logic [31:0] RST_GAINSEL_RAMP = 32'd10;
    localparam logic [31:0] RST_FB_ON        = 32'd1;
    localparam logic [31:0] RST_CONST_STEP   = 32'd100;

    typedef enum logic [2:0] {
        PS_IDLE = 3'd0,
        PS_HDR2 = 3'd1,
        PS_ADDR = 3'd2,
        PS_DATA = 3'd3,
        PS_TRL1 = 3'd4,
        PS_TRL2 = 3'd5
    } parser_state_t;

    function automatic logic addr_valid(input logic [7:0] a);
        return (a >= ADDR_FREQ_CNT) && (a <= ADDR_CONST_STEP);
    endfunction

endpackage

// File: rtl/uart_rx_byte.sv
// 8N1 UART byte receiver: 2-FF synchroniser, glitch-rejecting start detect and
// mid-bit sampling. Emits a one-cycle byte_valid or stop_err per received byte.
module uart_rx_byte
#(
    parameter int CLKS_PER_BIT = 868
)
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic       byte_valid,
    output logic [7:0] byte_data,
    output logic       stop_err
);

    localparam int CW = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);

    localparam logic [1:0] RX_IDLE  = 2'd0;
    localparam logic [1:0] RX_START = 2'd1;
    localparam logic [1:0] RX_DATA  = 2'd2;
    localparam logic [1:0] RX_STOP  = 2'd3;

    logic          rx_meta_r;
    logic          rx_sync_r;
    logic          rx_prev_r;
    logic [1:0]    rx_state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_r;
    logic [7:0]    shift_r;
    logic          byte_valid_r;
    logic [7:0]    byte_data_r;
    logic          stop_err_r;

    // Synchroniser, bit timing and byte assembly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_meta_r    <= 1'b1;
            rx_sync_r    <= 1'b1;
            rx_prev_r    <= 1'b1;
            rx_state_r   <= RX_IDLE;
            cnt_r        <= CNT_ZERO;
            bit_r        <= 3'd0;
            shift_r      <= 8'h00;
            byte_valid_r <= 1'b0;
            byte_data_r  <= 8'h00;
            stop_err_r   <= 1'b0;
        end else begin
            rx_meta_r    <= rx;
            rx_sync_r    <= rx_meta_r;
            rx_prev_r    <= rx_sync_r;
            byte_valid_r <= 1'b0;
            stop_err_r   <= 1'b0;
            case (rx_state_r)
                RX_IDLE: begin
                    cnt_r <= CNT_ZERO;
                    bit_r <= 3'd0;
                    if (rx_prev_r && !rx_sync_r) begin
                        rx_state_r <= RX_START;
                    end
                end
                RX_START: begin
                    if (cnt_r == HALF_LAST) begin
                        cnt_r      <= CNT_ZERO;
                        // a line that is high again at mid start bit was a glitch
                        rx_state_r <= rx_sync_r ? RX_IDLE : RX_DATA;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                RX_DATA: begin
                    if (cnt_r == FULL_LAST) begin
                        cnt_r   <= CNT_ZERO;
                        shift_r <= {rx_sync_r, shift_r[7:1]};
                        bit_r   <= bit_r + 3'd1;
                        if (bit_r == 3'd7) begin
                            rx_state_r <= RX_STOP;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                RX_STOP: begin
                    if (cnt_r == FULL_LAST) begin
                        cnt_r      <= CNT_ZERO;
                        rx_state_r <= RX_IDLE;
                        if (rx_sync_r) begin
                            byte_valid_r <= 1'b1;
                            byte_data_r  <= shift_r;
                        end else begin
                            stop_err_r <= 1'b1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    rx_state_r <= RX_IDLE;
                end
            endcase
        end
    end

    assign byte_valid = byte_valid_r;
    assign byte_data  = byte_data_r;
    assign stop_err   = stop_err_r;

endmodule

// File: rtl/fog_param_uart_regs.sv
// UART command parser and parameter register bank driving the FOG core var_* inputs.
// Each valid 9-byte frame writes one register; everything else holds its default.
module fog_param_uart_regs
    import fog_param_pkg::*;
#(
    parameter int CLK_HZ       = 100000000,
    parameter int BAUD         = 115200,
    parameter int TIMEOUT_CLKS = 1000000
)
(
    input  logic        pll_clk_cpu_int,
    input  logic        RST_EXT_N,
    input  logic        i_rx,
    output logic [31:0] var_freq_cnt,
    output logic [31:0] var_amp_H,
    output logic [31:0] var_amp_L,
    output logic [31:0] var_wait_cnt,
    output logic [31:0] var_err_offset,
    output logic [31:0] var_avg_sel,
    output logic [31:0] var_gainSel_step,
    output logic [31:0] var_gainSel_ramp,
    output logic [31:0] var_fb_ON,
    output logic [31:0] var_const_step,
    output logic        var_polarity,
    output logic        o_param_update,
    output logic [7:0]  o_param_addr,
    output logic        o_frame_err
);

    localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CLKS - 1);
    localparam logic [TW-1:0] TMO_ZERO = TW'(0);
    localparam logic [TW-1:0] TMO_ONE  = TW'(1);

    logic          byte_valid_s;
    logic [7:0]    byte_data_s;
    logic          stop_err_s;

    parser_state_t state_r, state_nx_s;
    logic [7:0]    addr_r, addr_nx_s;
    logic [31:0]   buf_r, buf_nx_s;
    logic [1:0]    idx_r, idx_nx_s;
    logic [TW-1:0] tmo_r;
    logic          wr_en_s;
    logic          bad_s;

    logic [31:0] freq_cnt_r, amp_h_r, amp_l_r, wait_cnt_r, err_offset_r, avg_sel_r;
    logic [31:0] gainsel_step_r, gainsel_ramp_r, fb_on_r, const_step_r;
    logic        polarity_r, update_r, frame_err_r;
    logic [7:0]  param_addr_r;

    uart_rx_byte #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
        .clk        (pll_clk_cpu_int),
        .rst_n      (RST_EXT_N),
        .rx         (i_rx),
        .byte_valid (byte_valid_s),
        .byte_data  (byte_data_s),
        .stop_err   (stop_err_s)
    );

    // Frame parser next-state, write strobe and bad-frame detection
    always_comb begin
        state_nx_s = state_r;
        addr_nx_s  = addr_r;
        buf_nx_s   = buf_r;
        idx_nx_s   = idx_r;
        wr_en_s    = 1'b0;
        bad_s      = 1'b0;
        if (stop_err_s) begin
            state_nx_s = PS_IDLE;
        end else if (byte_valid_s) begin
            case (state_r)
                PS_IDLE: begin
                    state_nx_s = (byte_data_s == HDR0) ? PS_HDR2 : PS_IDLE;
                end
                PS_HDR2: begin
                    if (byte_data_s == HDR1) begin
                        state_nx_s = PS_ADDR;
                    end else if (byte_data_s == HDR0) begin
                        state_nx_s = PS_HDR2;
                    end else begin
                        state_nx_s = PS_IDLE;
                    end
                end
                PS_ADDR: begin
                    addr_nx_s  = byte_data_s;
                    idx_nx_s   = 2'd0;
                    state_nx_s = PS_DATA;
                end
                PS_DATA: begin
                    buf_nx_s   = {buf_r[23:0], byte_data_s};
                    idx_nx_s   = idx_r + 2'd1;
                    state_nx_s = (idx_r == 2'd3) ? PS_TRL1 : PS_DATA;
                end
                PS_TRL1: begin
                    if (byte_data_s == TRL0) begin
                        state_nx_s = PS_TRL2;
                    end else begin
                        bad_s      = 1'b1;
                        state_nx_s = PS_IDLE;
                    end
                end
                PS_TRL2: begin
                    if ((byte_data_s == TRL1) && addr_valid(addr_r)) begin
                        wr_en_s = 1'b1;
                    end else begin
                        bad_s = 1'b1;
                    end
                    state_nx_s = PS_IDLE;
                end
                default: begin
                    state_nx_s = PS_IDLE;
                end
            endcase
        end else if ((state_r != PS_IDLE) && (tmo_r == TMO_LAST)) begin
            state_nx_s = PS_IDLE;
        end else begin
            state_nx_s = state_r;
        end
    end

    // Parser state, frame buffer and inter-byte timeout counter
    always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
        if (!RST_EXT_N) begin
            state_r <= PS_IDLE;
            addr_r  <= 8'h00;
            buf_r   <= 32'h0000_0000;
            idx_r   <= 2'd0;
            tmo_r   <= TMO_ZERO;
        end else begin
            state_r <= state_nx_s;
            addr_r  <= addr_nx_s;
            buf_r   <= buf_nx_s;
            idx_r   <= idx_nx_s;
            if (byte_valid_s || stop_err_s || (state_r == PS_IDLE) || (tmo_r == TMO_LAST)) begin
                tmo_r <= TMO_ZERO;
            end else begin
                tmo_r <= tmo_r + TMO_ONE;
            end
        end
    end

    // Parameter register bank and status pulses
    always_ff @(posedge pll_clk_cpu_int or negedge RST_EXT_N) begin
        if (!RST_EXT_N) begin
            freq_cnt_r     <= RST_FREQ_CNT;
            amp_h_r        <= RST_AMP_H;
            amp_l_r        <= RST_AMP_L;
            polarity_r     <= RST_POLARITY;
            wait_cnt_r     <= RST_WAIT_CNT;
            err_offset_r   <= RST_ERR_OFFSET;
            avg_sel_r      <= RST_AVG_SEL;
            gainsel_step_r <= RST_GAINSEL_STEP;
            gainsel_ramp_r <= RST_GAINSEL_RAMP;
            fb_on_r        <= RST_FB_ON;
            const_step_r   <= RST_CONST_STEP;
            update_r       <= 1'b0;
            frame_err_r    <= 1'b0;
            param_addr_r   <= 8'h00;
        end else begin
            update_r    <= wr_en_s;
            frame_err_r <= stop_err_s | bad_s;
            if (wr_en_s) begin
                param_addr_r <= addr_r;
                case (addr_r)
                    ADDR_FREQ_CNT:     freq_cnt_r     <= buf_r;
                    ADDR_AMP_H:        amp_h_r        <= buf_r;
                    ADDR_AMP_L:        amp_l_r        <= buf_r;
                    ADDR_POLARITY:     polarity_r     <= buf_r[0];
                    ADDR_WAIT_CNT:     wait_cnt_r     <= buf_r;
                    ADDR_ERR_OFFSET:   err_offset_r   <= buf_r;
                    ADDR_AVG_SEL:      avg_sel_r      <= buf_r;
                    ADDR_GAINSEL_STEP: gainsel_step_r <= buf_r;
                    ADDR_GAINSEL_RAMP: gainsel_ramp_r <= buf_r;
                    ADDR_FB_ON:        fb_on_r        <= buf_r;
                    ADDR_CONST_STEP:   const_step_r   <= buf_r;
                    default: begin
                    end
                endcase
            end
        end
    end

    assign var_freq_cnt     = freq_cnt_r;
    assign var_amp_H        = amp_h_r;
    assign var_amp_L        = amp_l_r;
    assign var_polarity     = polarity_r;
    assign var_wait_cnt     = wait_cnt_r;
    assign var_err_offset   = err_offset_r;
    assign var_avg_sel      = avg_sel_r;
    assign var_gainSel_step = gainsel_step_r;
    assign var_gainSel_ramp = gainsel_ramp_r;
    assign var_fb_ON        = fb_on_r;
    assign var_const_step   = const_step_r;
    assign o_param_update   = update_r;
    assign o_param_addr     = param_addr_r;
    assign o_frame_err      = frame_err_r;

endmodule

// File: tb/tb_fog_param_uart_regs.sv
// Bench for fog_param_uart_regs: table of frames, hand-written corner sequences
// and random back-to-back frames, all checked against a frame-level register model.
module tb_fog_param_uart_regs;

    localparam int CPB = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic [31:0] var_freq_cnt, var_amp_H, var_amp_L, var_wait_cnt, var_err_offset;
    logic [31:0] var_avg_sel, var_gainSel_step, var_gainSel_ramp, var_fb_ON, var_const_step;
    logic        var_polarity, o_param_update, o_frame_err;
    logic [7:0]  o_param_addr;

    always #5 clk = ~clk;

    fog_param_uart_regs #(.CLK_HZ(1000000), .BAUD(100000), .TIMEOUT_CLKS(500)) dut (
        .pll_clk_cpu_int  (clk),
        .RST_EXT_N        (rst_n),
        .i_rx             (rx),
        .var_freq_cnt     (var_freq_cnt),
        .var_amp_H        (var_amp_H),
        .var_amp_L        (var_amp_L),
        .var_wait_cnt     (var_wait_cnt),
        .var_err_offset   (var_err_offset),
        .var_avg_sel      (var_avg_sel),
        .var_gainSel_step (var_gainSel_step),
        .var_gainSel_ramp (var_gainSel_ramp),
        .var_fb_ON        (var_fb_ON),
        .var_const_step   (var_const_step),
        .var_polarity     (var_polarity),
        .o_param_update   (o_param_update),
        .o_param_addr     (o_param_addr),
        .o_frame_err      (o_frame_err)
    );

    int vectors = 0;
    int miscompares = 0;
    int upd_cnt = 0;
    int err_cnt = 0;

    // pulse counters sampled away from the active edge
    always @(negedge clk) begin
        if (o_param_update === 1'b1) upd_cnt++;
        if (o_frame_err === 1'b1) err_cnt++;
    end

    logic [31:0] mdl [1:11];
    logic [7:0]  mdl_addr;

    task automatic model_reset();
        mdl[1] = 32'd1000; mdl[2] = 32'd5000; mdl[3] = 32'd5000; mdl[4] = 32'd0;
        mdl[5] = 32'd50;   mdl[6] = 32'd0;    mdl[7] = 32'd10;   mdl[8] = 32'd5;
        mdl[9] = 32'd10;   mdl[10] = 32'd1;   mdl[11] = 32'd100;
        mdl_addr = 8'h00;
    endtask

    function automatic bit frame_ok(input logic [7:0] a, input logic [7:0] t0,
                                    input logic [7:0] t1, input int bad_idx);
        return (a >= 8'd1) && (a <= 8'd11) && (t0 == 8'h55) && (t1 == 8'h56) && (bad_idx < 0);
    endfunction

    task automatic model_write(input logic [7:0] a, input logic [31:0] d);
        mdl[a] = (a == 8'd4) ? {31'd0, d[0]} : d;
        mdl_addr = a;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " freq_cnt"},     var_freq_cnt,       mdl[1]);
        chk({tag, " amp_H"},        var_amp_H,          mdl[2]);
        chk({tag, " amp_L"},        var_amp_L,          mdl[3]);
        chk({tag, " polarity"},     {31'd0, var_polarity}, mdl[4]);
        chk({tag, " wait_cnt"},     var_wait_cnt,       mdl[5]);
        chk({tag, " err_offset"},   var_err_offset,     mdl[6]);
        chk({tag, " avg_sel"},      var_avg_sel,        mdl[7]);
        chk({tag, " gainSel_step"}, var_gainSel_step,   mdl[8]);
        chk({tag, " gainSel_ramp"}, var_gainSel_ramp,   mdl[9]);
        chk({tag, " fb_ON"},        var_fb_ON,          mdl[10]);
        chk({tag, " const_step"},   var_const_step,     mdl[11]);
        chk({tag, " param_addr"},   {24'd0, o_param_addr}, {24'd0, mdl_addr});
    endtask

    task automatic send_byte(input logic [7:0] b, input bit stop_ok);
        @(negedge clk);
        rx = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx = stop_ok ? 1'b1 : 1'b0;
        repeat (CPB - 1) @(negedge clk);
        if (!stop_ok) begin
            @(negedge clk);
            rx = 1'b1;
            repeat (CPB) @(negedge clk);
        end
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [31:0] d, input logic [7:0] t0,
                              input logic [7:0] t1, input int bad_idx);
        logic [7:0] fb [9];
        fb = '{8'hAB, 8'hBA, a, d[31:24], d[23:16], d[15:8], d[7:0], t0, t1};
        for (int k = 0; k < 9; k++) send_byte(fb[k], k != bad_idx);
    endtask

    task automatic settle_and_check(input string tag, input int upd0, input int err0,
                                    input int exp_upd, input int exp_err);
        repeat (3 * CPB) @(negedge clk);
        chk({tag, " update pulses"}, upd_cnt - upd0, exp_upd);
        chk({tag, " error pulses"},  err_cnt - err0, exp_err);
        check_all(tag);
    endtask

    typedef struct {
        logic [7:0]  addr;
        logic [31:0] data;
        logic [7:0]  t0;
        logic [7:0]  t1;
        int          bad_idx;
        int          exp_upd;
        int          exp_err;
    } vec_t;

    vec_t tbl [9];

    initial begin
        int u0, e0, eu, ee;
        logic [7:0] seq [$];

        tbl[0] = '{8'h01, 32'h0000_07D0, 8'h55, 8'h56, -1, 1, 0};
        tbl[1] = '{8'h04, 32'h0000_0003, 8'h55, 8'h56, -1, 1, 0};
        tbl[2] = '{8'h02, 32'h0000_1234, 8'h55, 8'h57, -1, 0, 1};
        tbl[3] = '{8'h0C, 32'h0000_0001, 8'h55, 8'h56, -1, 0, 1};
        tbl[4] = '{8'h03, 32'h0000_1234, 8'h55, 8'h56,  4, 0, 1};
        tbl[5] = '{8'h03, 32'h0000_0042, 8'h55, 8'h56, -1, 1, 0};
        tbl[6] = '{8'h06, 32'hFFFF_FFFF, 8'h54, 8'h56, -1, 0, 1};
        tbl[7] = '{8'h00, 32'h0000_0009, 8'h55, 8'h56, -1, 0, 1};
        tbl[8] = '{8'h04, 32'hFFFF_FFFE, 8'h55, 8'h56, -1, 1, 0};

        model_reset();
        repeat (5) @(negedge clk);
        rst_n = 1'b1;
        repeat (50) @(negedge clk);
        chk("reset update pulses", upd_cnt, 0);
        chk("reset error pulses", err_cnt, 0);
        check_all("reset");

        for (int v = 0; v < 9; v++) begin
            u0 = upd_cnt; e0 = err_cnt;
            send_frame(tbl[v].addr, tbl[v].data, tbl[v].t0, tbl[v].t1, tbl[v].bad_idx);
            if (frame_ok(tbl[v].addr, tbl[v].t0, tbl[v].t1, tbl[v].bad_idx))
                model_write(tbl[v].addr, tbl[v].data);
            settle_and_check($sformatf("table%0d", v), u0, e0, tbl[v].exp_upd, tbl[v].exp_err);
        end

        // repeated header byte before a valid const_step write
        u0 = upd_cnt; e0 = err_cnt;
        seq = '{8'hAB, 8'hAB, 8'hBA, 8'h0B, 8'hFF, 8'hFF, 8'hFF, 8'h9C, 8'h55, 8'h56};
        foreach (seq[k]) send_byte(seq[k], 1'b1);
        model_write(8'h0B, 32'hFFFF_FF9C);
        settle_and_check("double header", u0, e0, 1, 0);

        // partial frame abandoned by the idle timeout, then a full frame
        u0 = upd_cnt; e0 = err_cnt;
        seq = '{8'hAB, 8'hBA, 8'h02, 8'h00, 8'h00};
        foreach (seq[k]) send_byte(seq[k], 1'b1);
        repeat (600) @(negedge clk);
        send_frame(8'h02, 32'h0000_2222, 8'h55, 8'h56, -1);
        model_write(8'h02, 32'h0000_2222);
        settle_and_check("timeout", u0, e0, 1, 0);

        // reset after the fifth byte of a frame
        seq = '{8'hAB, 8'hBA, 8'h02, 8'h00, 8'h00};
        foreach (seq[k]) send_byte(seq[k], 1'b1);
        repeat (CPB) @(negedge clk);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("in reset");
        chk("in reset update", {31'd0, o_param_update}, 32'd0);
        chk("in reset frame_err", {31'd0, o_frame_err}, 32'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        u0 = upd_cnt; e0 = err_cnt;
        seq = '{8'h00, 8'h07, 8'h55, 8'h56};
        foreach (seq[k]) send_byte(seq[k], 1'b1);
        settle_and_check("after reset", u0, e0, 0, 0);

        // random pairs of back-to-back frames
        for (int r = 0; r < 15; r++) begin
            u0 = upd_cnt; e0 = err_cnt; eu = 0; ee = 0;
            for (int f = 0; f < 2; f++) begin
                logic [7:0]  a;
                logic [31:0] d;
                logic [7:0]  t0, t1;
                a = 8'($urandom_range(0, 14));
                d = $urandom;
                t0 = 8'h55; t1 = 8'h56;
                if ($urandom_range(0, 4) == 0) begin
                    if ($urandom_range(0, 1) == 0) t0 = 8'h54; else t1 = 8'h57;
                end
                send_frame(a, d, t0, t1, -1);
                if (frame_ok(a, t0, t1, -1)) begin
                    model_write(a, d);
                    eu++;
                end else begin
                    ee++;
                end
            end
            settle_and_check($sformatf("random%0d", r), u0, e0, eu, ee);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
